// File: rtl/counter_updown_param_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
package counter_updown_param_pkg;

    // Boundary behaviour selected by the mode input.
    localparam logic CNT_MODE_WRAP = 1'b0;
    localparam logic CNT_MODE_SAT  = 1'b1;

    // Count direction selected by the dir input.
    localparam logic CNT_DIR_UP   = 1'b1;
    localparam logic CNT_DIR_DOWN = 1'b0;

    // Width of the prescaler phase register; a divide-by-1 prescaler still
    // keeps one (always-zero) bit so the port list stays uniform.
    function automatic int phase_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable-gated prescaler: tick is high on every PRESCALE-th enabled edge.
// The phase advances only while en is high and restarts on reset or clear.
module counter_prescaler
    import counter_updown_param_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int              PW   = phase_width(PRESCALE);
    localparam logic [PW-1:0]   LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    // With PRESCALE=1 LAST is 0 and phase never leaves 0, so tick is constant 1.
    assign tick = (phase == LAST);

    // Phase register: reset/clear restart the cycle, otherwise count enabled edges.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            phase <= '0;
        end else if (en) begin
            phase <= tick ? '0 : phase + PW'(1);
        end
    end

endmodule

// File: rtl/counter_updown_param.sv
// Parametrised up/down counter with prescaled stepping, parallel load and
// wrap/saturate boundary handling. count, tc and sat are all registered.
// Priority per edge: reset > load > step > hold.
module counter_updown_param
    import counter_updown_param_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_VAL   = '1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               PRESCALE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             sat
);

    logic             tick;
    logic             step;
    logic [WIDTH-1:0] count_next;
    logic             tc_next;
    logic             sat_next;

    // A load clears the phase and takes priority over its en, so no advance
    // happens in a load cycle.
    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (load),
        .en    (en),
        .tick  (tick)
    );

    assign step = en && tick;

    // Next-state logic: load clamps to MAX_VAL; a step moves, wraps or holds at a bound.
    always_comb begin
        count_next = count;
        tc_next    = 1'b0;
        sat_next   = sat;
        if (load) begin
            count_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
            sat_next   = 1'b0;
        end else if (step) begin
            if (dir == CNT_DIR_UP) begin
                if (count < MAX_VAL) begin
                    count_next = count + WIDTH'(1);
                    sat_next   = 1'b0;
                end else begin
                    tc_next = 1'b1;
                    if (mode == CNT_MODE_SAT) begin
                        count_next = MAX_VAL;
                        sat_next   = 1'b1;
                    end else begin
                        count_next = '0;
                        sat_next   = 1'b0;
                    end
                end
            end else begin
                if (count != '0) begin
                    count_next = count - WIDTH'(1);
                    sat_next   = 1'b0;
                end else begin
                    tc_next = 1'b1;
                    if (mode == CNT_MODE_SAT) begin
                        count_next = '0;
                        sat_next   = 1'b1;
                    end else begin
                        count_next = MAX_VAL;
                        sat_next   = 1'b0;
                    end
                end
            end
        end
    end

    // Output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RESET_VAL;
            tc    <= 1'b0;
            sat   <= 1'b0;
        end else begin
            count <= count_next;
            tc    <= tc_next;
            sat   <= sat_next;
        end
    end

endmodule
